// File: rtl/branch_resolve_pkg.sv
// Shared constants and state type for the execute-stage branch resolver.
// Used by branch_resolve and branch_taken_decode.
package branch_resolve_pkg;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } br_state_e;

endpackage

// File: rtl/branch_taken_decode.sv
// Combinational taken decision from opcode/funct3 and comparator flags.
// Kept standalone so a later predictor can reuse the same resolution rules.
module branch_taken_decode
  import branch_resolve_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       breq,
  input  logic       brlt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OPCODE_BRANCH: begin
        case (funct3)
          F3_BEQ:           taken = breq;
          F3_BNE:           taken = ~breq;
          F3_BLT, F3_BLTU:  taken = brlt;
          F3_BGE, F3_BGEU:  taken = ~brlt;
          default:          taken = 1'b0;
        endcase
      end
      OPCODE_JAL, OPCODE_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves control transfers at execute, issues PC redirects and IF/ID flushes.
// Optional BRANCH_STATS_EN adds saturating branch/taken/misalign counters.
//
// state    | meaning
// IDLE     | accepting execute instrs
// REDIRECT | redirect_valid_o held until fetch accepts; flush asserted
// SQUASH   | flush held FLUSH_CYCLES cycles after redirect accepted
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              breq_i,
  input  logic              brlt_i,
  input  logic [DWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] imm_i,
  output logic              redirect_valid_o,
  input  logic              redirect_ready_i,
  output logic [DWIDTH-1:0] redirect_pc_o,
  output logic              flush_o,
  output logic              misalign_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches_o,
  output logic [31:0]       stat_taken_o,
  output logic [31:0]       stat_misalign_o
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  br_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic              mis_q, mis_d;
  logic              taken;
  logic              accept;
  logic              is_jalr;
  logic [DWIDTH-1:0] sum;
  logic [DWIDTH-1:0] target;

  branch_taken_decode u_decode (
    .opcode (opcode_i),
    .funct3 (funct3_i),
    .breq   (breq_i),
    .brlt   (brlt_i),
    .taken  (taken)
  );

  assign accept  = ex_valid_i & ex_ready_o;
  assign is_jalr = (opcode_i == OPCODE_JALR);
  assign sum     = (is_jalr ? rs1_i : pc_i) + imm_i;
  assign target  = is_jalr ? {sum[DWIDTH-1:1], 1'b0} : sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && taken) begin
          state_d = REDIRECT;
          pc_d    = target;
          mis_d   = target[1];
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = SQUASH;
          cnt_d   = CNT_INIT;
        end
      end
      SQUASH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ex_ready_o       = (state_q == IDLE);
  assign redirect_valid_o = (state_q == REDIRECT);
  assign flush_o          = (state_q == REDIRECT) || (state_q == SQUASH);
  assign redirect_pc_o    = pc_q;
  assign misalign_o       = mis_q;

`ifdef BRANCH_STATS_EN
  logic is_ctrl;
  assign is_ctrl = (opcode_i == OPCODE_BRANCH) || (opcode_i == OPCODE_JAL) ||
                   (opcode_i == OPCODE_JALR);

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches_o <= '0;
      stat_taken_o    <= '0;
      stat_misalign_o <= '0;
    end else begin
      if (accept && is_ctrl && (stat_branches_o != '1))
        stat_branches_o <= stat_branches_o + 32'd1;
      if (accept && taken && (stat_taken_o != '1))
        stat_taken_o <= stat_taken_o + 32'd1;
      if (misalign_o && (stat_misalign_o != '1))
        stat_misalign_o <= stat_misalign_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: vector table, corner sequences, random vs model.
// Stats ports are exercised when BRANCH_STATS_EN is defined.
module tb_branch_resolve;

  localparam int DW = 32;
  localparam int FC = 2;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid, ex_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          breq, brlt;
  logic [DW-1:0] pc, rs1, imm;
  logic          redirect_valid, redirect_ready;
  logic [DW-1:0] redirect_pc;
  logic          flush, misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0]   stat_branches, stat_taken, stat_misalign;
`endif

  always #5 clk = ~clk;

  branch_resolve #(.DWIDTH(DW), .FLUSH_CYCLES(FC)) dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid_i       (ex_valid),
    .ex_ready_o       (ex_ready),
    .opcode_i         (opcode),
    .funct3_i         (funct3),
    .breq_i           (breq),
    .brlt_i           (brlt),
    .pc_i             (pc),
    .rs1_i            (rs1),
    .imm_i            (imm),
    .redirect_valid_o (redirect_valid),
    .redirect_ready_i (redirect_ready),
    .redirect_pc_o    (redirect_pc),
    .flush_o          (flush),
    .misalign_o       (misalign)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches_o  (stat_branches),
    .stat_taken_o     (stat_taken),
    .stat_misalign_o  (stat_misalign)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int e_br = 0, e_tk = 0, e_mis = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          eq;
    bit          lt;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] imm;
    bit          tk;
    logic [31:0] tgt;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: condition is "equal" or "less-than", funct3[0] inverts it.
  function automatic bit model_taken(input logic [6:0] op, input logic [2:0] f3,
                                     input bit eq, input bit lt);
    bit cond;
    if (op == OP_JAL || op == OP_JALR) return 1'b1;
    if (op != OP_BR) return 1'b0;
    if (f3 == 3'b010 || f3 == 3'b011) return 1'b0;
    cond = f3[2] ? lt : eq;
    return cond ^ f3[0];
  endfunction

  function automatic logic [31:0] model_target(input logic [6:0] op, input logic [31:0] p,
                                               input logic [31:0] r, input logic [31:0] i);
    logic [31:0] s;
    if (op == OP_JALR) begin
      s = r + i;
      s = s & 32'hFFFF_FFFE;
    end else begin
      s = p + i;
    end
    return s;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (!ex_ready && k < 50) begin
      step();
      k++;
    end
    chk("wait_idle_timeout", ex_ready, 1);
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input bit eq, input bit lt,
                       input logic [31:0] p, input logic [31:0] r, input logic [31:0] i);
    opcode = op; funct3 = f3; breq = eq; brlt = lt; pc = p; rs1 = r; imm = i;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input bit eq, input bit lt,
                           input logic [31:0] p, input logic [31:0] r, input logic [31:0] i,
                           input bit exp_tk, input logic [31:0] exp_tgt, input int stall);
    wait_idle();
    drive(op, f3, eq, lt, p, r, i);
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    if (op == OP_BR || op == OP_JAL || op == OP_JALR) e_br++;
    if (exp_tk) begin
      e_tk++;
      if (exp_tgt[1]) e_mis++;
      chk("redir_valid", redirect_valid, 1);
      chk("redir_pc", redirect_pc, exp_tgt);
      chk("misalign", misalign, exp_tgt[1]);
      chk("flush_in_redirect", flush, 1);
      chk("ready_busy", ex_ready, 0);
      for (int s = 0; s < stall; s++) begin
        step();
        chk("stall_valid", redirect_valid, 1);
        chk("stall_pc", redirect_pc, exp_tgt);
        chk("stall_misalign_low", misalign, 0);
      end
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
      for (int s = 0; s < FC; s++) begin
        chk("squash_flush", flush, 1);
        chk("squash_valid_low", redirect_valid, 0);
        step();
      end
      chk("post_flush_low", flush, 0);
      chk("post_ready", ex_ready, 1);
    end else begin
      chk("nt_valid", redirect_valid, 0);
      chk("nt_flush", flush, 0);
      chk("nt_ready", ex_ready, 1);
      chk("nt_misalign", misalign, 0);
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef BRANCH_STATS_EN
    chk({tag, "_stat_branches"}, stat_branches, e_br);
    chk({tag, "_stat_taken"},    stat_taken,    e_tk);
    chk({tag, "_stat_misalign"}, stat_misalign, e_mis);
`else
    chk({tag, "_idle_ready"}, ex_ready, 1);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{OP_BR,   3'b000, 1, 0, 32'h100,      32'h0,    32'h20,       1, 32'h120};
    vt[1]  = '{OP_BR,   3'b001, 1, 0, 32'h100,      32'h0,    32'h20,       0, 32'h0};
    vt[2]  = '{OP_JALR, 3'b000, 0, 0, 32'h500,      32'h1003, 32'h4,        1, 32'h1006};
    vt[3]  = '{OP_JALR, 3'b000, 0, 0, 32'h500,      32'h1001, 32'h0,        1, 32'h1000};
    vt[4]  = '{OP_JAL,  3'b000, 0, 0, 32'hFFFFFFF0, 32'h0,    32'h20,       1, 32'h10};
    vt[5]  = '{OP_BR,   3'b100, 0, 1, 32'h200,      32'h0,    32'hFFFFFFF8, 1, 32'h1F8};
    vt[6]  = '{OP_BR,   3'b101, 0, 1, 32'h200,      32'h0,    32'h8,        0, 32'h0};
    vt[7]  = '{OP_BR,   3'b111, 0, 0, 32'h300,      32'h0,    32'h6,        1, 32'h306};
    vt[8]  = '{OP_BR,   3'b010, 1, 1, 32'h300,      32'h0,    32'h6,        0, 32'h0};
    vt[9]  = '{7'h33,   3'b000, 1, 0, 32'h300,      32'h0,    32'h6,        0, 32'h0};
    vt[10] = '{OP_BR,   3'b001, 0, 0, 32'h400,      32'h0,    32'h40,       1, 32'h440};
    vt[11] = '{OP_BR,   3'b110, 0, 0, 32'h400,      32'h0,    32'h40,       0, 32'h0};

    reset = 1'b1; ex_valid = 1'b0; redirect_ready = 1'b0;
    drive(7'h0, 3'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    step(); step();
    chk("rst_valid", redirect_valid, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_ready", ex_ready, 1);
    chk_stats("rst");
    reset = 1'b0;
    step();

    foreach (vt[k])
      run_instr(vt[k].op, vt[k].f3, vt[k].eq, vt[k].lt, vt[k].pc, vt[k].rs1, vt[k].imm,
                vt[k].tk, vt[k].tgt, 1);
    chk_stats("table");

    // Back-to-back not-taken instrs, ex_valid held two cycles.
    wait_idle();
    drive(OP_BR, 3'b001, 1, 0, 32'h600, 32'h0, 32'h10);
    ex_valid = 1'b1;
    chk("b2b_ready0", ex_ready, 1);
    step();
    drive(OP_BR, 3'b000, 0, 0, 32'h604, 32'h0, 32'h10);
    chk("b2b_ready1", ex_ready, 1);
    chk("b2b_valid0", redirect_valid, 0);
    step();
    ex_valid = 1'b0;
    e_br += 2;
    chk("b2b_ready2", ex_ready, 1);
    chk("b2b_valid1", redirect_valid, 0);
    chk("b2b_flush", flush, 0);

    // Taken BLTU stalled 5 cycles; a JAL held on ex_valid must wait and then be taken.
    drive(OP_BR, 3'b110, 0, 1, 32'h800, 32'h0, 32'h10);
    ex_valid = 1'b1;
    step();
    drive(OP_JAL, 3'b000, 0, 0, 32'h900, 32'h0, 32'h8);
    e_br += 2; e_tk += 2;
    for (int s = 0; s < 5; s++) begin
      chk("stall5_valid", redirect_valid, 1);
      chk("stall5_pc", redirect_pc, 32'h810);
      chk("stall5_ready", ex_ready, 0);
      step();
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    for (int s = 0; s < FC; s++) begin
      chk("stall5_squash_ready", ex_ready, 0);
      step();
    end
    chk("held_ready", ex_ready, 1);
    step();
    ex_valid = 1'b0;
    chk("held_valid", redirect_valid, 1);
    chk("held_pc", redirect_pc, 32'h908);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    wait_idle();
    chk_stats("stall");

    // Randomized instrs against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      bit          eq, lt;
      logic [31:0] p, r, i;
      case ($urandom_range(0, 4))
        0, 1:    op = OP_BR;
        2:       op = OP_JAL;
        3:       op = OP_JALR;
        default: op = 7'h13;
      endcase
      f3 = 3'($urandom_range(0, 7));
      eq = 1'($urandom_range(0, 1));
      lt = 1'($urandom_range(0, 1));
      p  = $urandom;
      r  = $urandom;
      i  = $urandom;
      run_instr(op, f3, eq, lt, p, r, i, model_taken(op, f3, eq, lt),
                model_target(op, p, r, i), int'($urandom_range(0, 3)));
    end
    chk_stats("random");

    // Reset while squashing discards everything.
    wait_idle();
    drive(OP_BR, 3'b000, 1, 0, 32'h100, 32'h0, 32'h22);
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    chk("rs_pc", redirect_pc, 32'h122);
    chk("rs_misalign", misalign, 1);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("rs_in_squash", flush, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    e_br = 0; e_tk = 0; e_mis = 0;
    chk("rs_flush", flush, 0);
    chk("rs_valid", redirect_valid, 0);
    chk("rs_ready", ex_ready, 1);
    chk("rs_pc_clr", redirect_pc, 0);
    chk("rs_mis_clr", misalign, 0);
    chk_stats("rs");
    step();
    chk("rs_flush_after", flush, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
